// File: rtl/demultiplexer_binary_handshake_decoder.sv
// Binary selector to one-hot lane decoder with an out-of-range flag.
// An X/Z selector yields X one-hot bits; it is deliberately not masked.
module decoder_binary_to_one_hot #(
  parameter int ADDR_WIDTH   = 2,
  parameter int OUTPUT_COUNT = 3
) (
  input  logic [ADDR_WIDTH-1:0]   sel,
  output logic [OUTPUT_COUNT-1:0] onehot,
  output logic                    out_of_range
);

  // One extra bit so OUTPUT_COUNT == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] COUNT_EXT = (ADDR_WIDTH+1)'(OUTPUT_COUNT);

  for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_dec
    assign onehot[i] = ({1'b0, sel} == (ADDR_WIDTH+1)'(i));
  end

  assign out_of_range = ({1'b0, sel} >= COUNT_EXT);

endmodule

// File: rtl/demultiplexer_binary_handshake.sv
// Ready/valid demultiplexer: one registered stage routes each word to the lane
// addressed by its binary selector; out-of-range selectors are dropped and flagged.
module demultiplexer_binary_handshake #(
  parameter int WORD_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int OUTPUT_COUNT = 3
) (
  input  logic                               clock,
  input  logic                               clear_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ADDR_WIDTH-1:0]              in_selector,
  input  logic [WORD_WIDTH-1:0]              in_word,
  output logic [OUTPUT_COUNT-1:0]            out_valid,
  input  logic [OUTPUT_COUNT-1:0]            out_ready,
  output logic [WORD_WIDTH*OUTPUT_COUNT-1:0] words_out,
  output logic                               sel_error
);

  localparam int                        TOTAL_WIDTH = WORD_WIDTH * OUTPUT_COUNT;
  localparam logic [OUTPUT_COUNT-1:0]   LANES_NONE  = '0;

  logic                    buf_valid;
  logic [ADDR_WIDTH-1:0]   buf_sel;
  logic [WORD_WIDTH-1:0]   buf_word;

  logic [OUTPUT_COUNT-1:0] in_onehot;
  logic                    in_err;
  logic [OUTPUT_COUNT-1:0] buf_onehot;
  logic                    buf_err;
  logic [OUTPUT_COUNT-1:0] lane_en;
  logic [TOTAL_WIDTH-1:0]  lanes;
  logic                    drain;
  logic                    accept;
  logic                    load;

  decoder_binary_to_one_hot #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OUTPUT_COUNT (OUTPUT_COUNT)
  ) u_dec_in (
    .sel          (in_selector),
    .onehot       (in_onehot),
    .out_of_range (in_err)
  );

  decoder_binary_to_one_hot #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OUTPUT_COUNT (OUTPUT_COUNT)
  ) u_dec_buf (
    .sel          (buf_sel),
    .onehot       (buf_onehot),
    .out_of_range (buf_err)
  );

  // Output gated by clear_n so no downstream handshake completes in a reset cycle.
  assign lane_en   = (buf_valid && clear_n && !buf_err) ? buf_onehot : LANES_NONE;
  assign out_valid = lane_en;
  assign drain     = |(lane_en & out_ready);
  assign in_ready  = clear_n & (~buf_valid | drain);
  assign accept    = in_valid & in_ready;
  assign load      = accept & ~in_err & (|in_onehot);

  for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_lane
    assign lanes[i*WORD_WIDTH +: WORD_WIDTH] = buf_word & {WORD_WIDTH{lane_en[i]}};
  end
  assign words_out = lanes;

  // ---- stage p1: control state (reset) ----
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      buf_valid <= 1'b0;
      sel_error <= 1'b0;
    end else begin
      sel_error <= accept & in_err;
      if (load)
        buf_valid <= 1'b1;
      else if (drain)
        buf_valid <= 1'b0;
    end
  end

  // ---- stage p1: data hold (no reset; masked by buf_valid on output) ----
  always_ff @(posedge clock) begin
    if (load) begin
      buf_sel  <= in_selector;
      buf_word <= in_word;
    end
  end

endmodule

// File: tb/tb_demultiplexer_binary_handshake.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the routing rules.
module tb_demultiplexer_binary_handshake;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_selector;
  logic [7:0]  in_word;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [23:0] words_out;
  logic        sel_error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [1:0] sel; logic [7:0] word; } item_t;
  item_t hold_q[$];
  logic  err_exp;
  logic [7:0] seen_words[$];

  always #5 clock = ~clock;

  demultiplexer_binary_handshake #(
    .WORD_WIDTH   (8),
    .ADDR_WIDTH   (2),
    .OUTPUT_COUNT (3)
  ) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_selector (in_selector),
    .in_word     (in_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .words_out   (words_out),
    .sel_error   (sel_error)
  );

  // Model: at most one held word; the lane it addresses is the only one shown.
  function automatic logic [2:0] exp_valid();
    if (hold_q.size() == 0) return 3'b000;
    return 3'b001 << hold_q[0].sel;
  endfunction

  function automatic logic [23:0] exp_words();
    if (hold_q.size() == 0) return 24'h0;
    return {16'h0, hold_q[0].word} << (8 * hold_q[0].sel);
  endfunction

  function automatic logic exp_ready();
    if (!clear_n) return 1'b0;
    if (hold_q.size() == 0) return 1'b1;
    return out_ready[hold_q[0].sel];
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] w,
                       input logic [2:0] r);
    in_valid = v; in_selector = s; in_word = w; out_ready = r;
  endtask

  // Advance one clock edge and apply the handshake rules to the model.
  task automatic advance();
    logic acc;
    logic drn;
    @(posedge clock);
    if (!clear_n) begin
      hold_q.delete();
      err_exp = 1'b0;
    end else begin
      acc = in_valid && exp_ready();
      drn = (hold_q.size() != 0) && out_ready[hold_q[0].sel];
      if (drn) begin
        seen_words.push_back(hold_q[0].word);
        void'(hold_q.pop_front());
      end
      err_exp = acc && (in_selector >= 2'd3);
      if (acc && in_selector < 2'd3) hold_q.push_back('{sel: in_selector, word: in_word});
    end
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    drive(1'b1, 2'd1, 8'h5A, 3'b111);
    for (int c = 0; c < 2; c++) begin
      #4;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready got %b want 0", in_ready); end
      n_checks++;
      if (c == 1) begin
        if (out_valid !== 3'b000) begin n_fail++; $display("FAIL reset out_valid got %b want 000", out_valid); end
        if (words_out !== 24'h0) begin n_fail++; $display("FAIL reset words_out got %h want 0", words_out); end
        if (sel_error !== 1'b0) begin n_fail++; $display("FAIL reset sel_error got %b want 0", sel_error); end
        n_checks += 3;
      end
      advance();
    end
    clear_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 3'b111);
  endtask

  task automatic test_single_route();
    drive(1'b1, 2'd2, 8'hA5, 3'b111);
    #4;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single in_ready got %b want 1", in_ready); end
    n_checks++;
    advance();
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    #4;
    if (out_valid !== 3'b100) begin n_fail++; $display("FAIL single out_valid got %b want 100", out_valid); end
    if (words_out !== 24'hA5_00_00) begin n_fail++; $display("FAIL single words_out got %h want a50000", words_out); end
    n_checks += 2;
    advance();
    #4;
    if (out_valid !== 3'b000) begin n_fail++; $display("FAIL single drained out_valid got %b want 000", out_valid); end
    n_checks++;
    advance();
  endtask

  task automatic test_back_pressure();
    drive(1'b1, 2'd1, 8'h3C, 3'b000);
    advance();
    drive(1'b1, 2'd0, 8'h11, 3'b000);
    for (int c = 0; c < 4; c++) begin
      #4;
      if (out_valid !== 3'b010) begin n_fail++; $display("FAIL bp_hold out_valid got %b want 010", out_valid); end
      if (words_out !== 24'h00_3C_00) begin n_fail++; $display("FAIL bp_hold words_out got %h want 003c00", words_out); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold in_ready got %b want 0", in_ready); end
      n_checks += 3;
      advance();
    end
    drive(1'b1, 2'd0, 8'h11, 3'b010);
    #4;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
    n_checks++;
    advance();
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    #4;
    if (out_valid !== 3'b001 || words_out !== 24'h00_00_11) begin
      n_fail++; $display("FAIL bp_second got %b/%h want 001/000011", out_valid, words_out);
    end
    n_checks++;
    advance();
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1'b1, sels[c], 8'(c + 1), 3'b111);
      else       drive(1'b0, 2'd0, 8'h00, 3'b111);
      #4;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream in_ready cyc %0d got %b want 1", c, in_ready); end
      n_checks++;
      if (c > 0) begin
        if (out_valid !== (3'b001 << sels[c-1]) || words_out !== ({16'h0, 8'(c)} << (8 * sels[c-1]))) begin
          n_fail++; $display("FAIL stream lane cyc %0d got %b/%h want lane %0d word %0d", c, out_valid, words_out, sels[c-1], c);
        end
        n_checks++;
      end
      advance();
    end
  endtask

  task automatic test_bad_selector();
    drive(1'b1, 2'd3, 8'hFF, 3'b111);
    #4;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL badsel in_ready got %b want 1", in_ready); end
    n_checks++;
    advance();
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    #4;
    if (sel_error !== 1'b1 || out_valid !== 3'b000) begin
      n_fail++; $display("FAIL badsel pulse got err=%b valid=%b want 1/000", sel_error, out_valid);
    end
    n_checks++;
    advance();
    #4;
    if (sel_error !== 1'b0 || out_valid !== 3'b000) begin
      n_fail++; $display("FAIL badsel after got err=%b valid=%b want 0/000", sel_error, out_valid);
    end
    n_checks++;
    advance();
  endtask

  task automatic test_reset_mid_hold();
    drive(1'b1, 2'd0, 8'h77, 3'b000);
    advance();
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    clear_n = 1'b0;
    #4;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset in_ready got %b want 0", in_ready); end
    n_checks++;
    advance();
    clear_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    for (int c = 0; c < 2; c++) begin
      #4;
      if (out_valid !== 3'b000 || words_out !== 24'h0) begin
        n_fail++; $display("FAIL midreset lost got %b/%h want 000/0", out_valid, words_out);
      end
      n_checks++;
      advance();
    end
  endtask

  task automatic test_random();
    seen_words.delete();
    for (int c = 0; c < 400; c++) begin
      clear_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            3'($urandom));
      #4;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rand in_ready cyc %0d got %b want %b", c, in_ready, exp_ready()); end
      n_checks++;
      if (clear_n) begin
        if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rand out_valid cyc %0d got %b want %b", c, out_valid, exp_valid()); end
        if (words_out !== exp_words()) begin n_fail++; $display("FAIL rand words_out cyc %0d got %h want %h", c, words_out, exp_words()); end
        if (sel_error !== err_exp) begin n_fail++; $display("FAIL rand sel_error cyc %0d got %b want %b", c, sel_error, err_exp); end
        n_checks += 3;
      end
      advance();
    end
    clear_n = 1'b1;
    if (seen_words.size() < 50) begin n_fail++; $display("FAIL rand drained count got %0d want >=50", seen_words.size()); end
    n_checks++;
  endtask

  initial begin
    clear_n = 1'b0;
    err_exp = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    @(posedge clock);
    #1;
    test_reset();
    test_single_route();
    test_back_pressure();
    test_back_to_back();
    test_bad_selector();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
